// File: rtl/io_bus_master.sv
// IO bus initiator: one command -> one strobe/wait IO transaction -> one response.
// Optional WAIT timeout compiled in with `define IOBM_TIMEOUT_EN.
module io_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] IO_Address,
  output logic        IO_Addr_Strobe,
  output logic [3:0]  IO_Byte_Enable,
  output logic [31:0] IO_Write_Data,
  output logic        IO_Write_Strobe,
  output logic        IO_Read_Strobe,
  input  logic [31:0] IO_Read_Data,
  input  logic        IO_Ready
);

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        as_q, as_d, ws_q, ws_d, rs_q, rs_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        timeout_hit;

  logic cmd_fire, rsp_fire;
  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

`ifdef IOBM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts WAIT cycles already spent without IO_Ready.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StStrobe) begin
      cnt_d = '0;
    end else if (state_q == StWait && !IO_Ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StWait) && !IO_Ready &&
                       (32'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    as_d        = 1'b0;
    ws_d        = 1'b0;
    rs_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          state_d = StStrobe;
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          as_d    = 1'b1;
          ws_d    = cmd_write;
          rs_d    = ~cmd_write;
        end
      end
      StStrobe: state_d = StWait;
      StWait: begin
        // IO_Ready beats a coincident terminal count.
        if (IO_Ready) begin
          state_d     = StResp;
          rdata_d     = wr_q ? 32'h0 : IO_Read_Data;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = StResp;
          rdata_d     = ERR_RDATA;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_fire) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      as_q        <= 1'b0;
      ws_q        <= 1'b0;
      rs_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      as_q        <= as_d;
      ws_q        <= ws_d;
      rs_q        <= rs_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;
`ifdef IOBM_TIMEOUT_EN
  assign rsp_err         = err_q;
`else
  assign rsp_err         = 1'b0;
`endif
  assign busy            = busy_q;
  assign IO_Address      = addr_q;
  assign IO_Byte_Enable  = be_q;
  assign IO_Write_Data   = wdata_q;
  assign IO_Addr_Strobe  = as_q;
  assign IO_Write_Strobe = ws_q;
  assign IO_Read_Strobe  = rs_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed cases then random transactions against a
// transaction-level model (expected response from command, responder delay, timeout).
module tb_io_bus_master;

  localparam int unsigned T = 4;
`ifdef IOBM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK, RST;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] IO_Address, IO_Write_Data, IO_Read_Data;
  logic        IO_Addr_Strobe, IO_Write_Strobe, IO_Read_Strobe, IO_Ready;
  logic [3:0]  IO_Byte_Enable;

  int n_cmp = 0;
  int n_err = 0;

  io_bus_master #(.TIMEOUT_CYCLES(T), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy),
    .IO_Address(IO_Address), .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Byte_Enable(IO_Byte_Enable),
    .IO_Write_Data(IO_Write_Data), .IO_Write_Strobe(IO_Write_Strobe),
    .IO_Read_Strobe(IO_Read_Strobe), .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; d = WAIT cycles before responder asserts IO_Ready.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int d, input logic [31:0] rd,
                     input int hold, input logic ready_in_strobe);
    logic        exp_err;
    logic [31:0] exp_rdata;
    exp_err   = TO_EN && (d >= int'(T));
    exp_rdata = exp_err ? 32'hDEAD_BEEF : (wr ? 32'h0 : rd);

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
    chk("idle_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_be = 4'($urandom); cmd_wdata = $urandom;
    IO_Ready = ready_in_strobe; IO_Read_Data = $urandom;
    chk("strobe_as", IO_Addr_Strobe, 1);
    chk("strobe_ws", IO_Write_Strobe, wr);
    chk("strobe_rs", IO_Read_Strobe, !wr);
    chk("strobe_addr", IO_Address, addr);
    chk("strobe_be", IO_Byte_Enable, be);
    chk("strobe_wdata", IO_Write_Data, wd);
    chk("strobe_cmd_ready", cmd_ready, 0);
    chk("strobe_busy", busy, 1);
    tick();
    for (int i = 0; i < 64; i++) begin
      IO_Ready     = (i == d);
      IO_Read_Data = (i == d) ? rd : $urandom;
      chk("wait_strobes", {IO_Addr_Strobe, IO_Write_Strobe, IO_Read_Strobe}, 0);
      chk("wait_addr", IO_Address, addr);
      chk("wait_be", IO_Byte_Enable, be);
      chk("wait_rsp_valid", rsp_valid, 0);
      tick();
      if (i == d || (TO_EN && i == int'(T) - 1)) break;
    end
    IO_Ready = 1'b0;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp_rdata);
    chk("resp_err", rsp_err, exp_err);
    cmd_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      IO_Ready = 1'($urandom); IO_Read_Data = $urandom;
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rdata);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_as", IO_Addr_Strobe, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0; IO_Ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_addr_kept", IO_Address, addr);
  endtask

  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; IO_Read_Data = '0; IO_Ready = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_addr", IO_Address, 0);
    RST = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Directed: write, delayed read, response backpressure, IO_Ready during strobe.
    txn(1'b1, 32'hC000_0000, 4'h1, 32'h0000_00A5, 0, 32'h1234_5678, 0, 1'b0);
    txn(1'b0, 32'h0000_0004, 4'hF, 32'h0, 3, 32'h0000_000B, 0, 1'b0);
    txn(1'b0, 32'h0000_0010, 4'h3, 32'h0, 1, 32'h5555_AAAA, 5, 1'b0);
    txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 2, 32'h0BAD_F00D, 1, 1'b1);
    if (TO_EN) begin
      txn(1'b0, 32'h0000_0030, 4'hF, 32'h0, 1000, 32'h1111_2222, 3, 1'b0);
      txn(1'b1, 32'h0000_0034, 4'hF, 32'h77, int'(T) - 1, 32'h0, 0, 1'b0);
    end

    // Reset during WAIT aborts; late IO_Ready is ignored.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_be = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    RST = 1'b1; IO_Ready = 1'b1; IO_Read_Data = 32'hFFFF_FFFF;
    tick();
    chk("rstw_cmd_ready", cmd_ready, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_addr", IO_Address, 0);
    chk("rstw_strobes", {IO_Addr_Strobe, IO_Write_Strobe, IO_Read_Strobe}, 0);
    chk("rstw_rdata", rsp_rdata, 0);
    chk("rstw_err", rsp_err, 0);
    chk("rstw_be_wdata", {IO_Byte_Enable, IO_Write_Data}, 0);
    RST = 1'b0;
    tick();
    tick();
    IO_Ready = 1'b0;
    chk("rstw_after_rsp_valid", rsp_valid, 0);
    chk("rstw_after_busy", busy, 0);
    chk("rstw_after_cmd_ready", cmd_ready, 1);
    txn(1'b0, 32'h0000_0044, 4'hF, 32'h0, 1, 32'hCAFE_0001, 0, 1'b0);

    // Random transactions.
    for (int k = 0; k < 20; k++) begin
      txn(1'($urandom), $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 5)),
          $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
